// File: rtl/beta_irq_ctrl_pkg.sv
// beta_irq_pkg: shared types and register map constants for the Beta interrupt controller.
package beta_irq_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, ASSERT = 2'd1, SERVICE = 2'd2} irq_state_t;
    localparam logic [1:0] OFF_PEND = 2'd0;
    localparam logic [1:0] OFF_MASK = 2'd1;
    localparam logic [1:0] OFF_CLR = 2'd2;
    localparam logic [1:0] OFF_EOI = 2'd3;
    localparam logic [31:0] ID_NONE = 32'hFFFF_FFFF;
endpackage

// File: rtl/beta_irq_ctrl_if.sv
// beta_irq_ctrl_if: Beta data-bus slice seen by the interrupt controller.
interface beta_irq_ctrl_if;
    logic [31:0] memAddr;
    logic [31:0] memWriteData;
    logic [31:0] irqReadData;
    logic MemWrite;
    logic MemRead;
    logic irqHit;
    modport master(output memAddr, memWriteData, MemWrite, MemRead, input irqReadData, irqHit);
    modport slave(input memAddr, memWriteData, MemWrite, MemRead, output irqReadData, irqHit);
endinterface

// File: rtl/beta_irq_ctrl_prio_enc.sv
// irq_prio_enc: lowest-numbered active source wins; ID_NONE when nothing is active.
import beta_irq_pkg::*;
module irq_prio_enc #(
    parameter int NSRC = 8
) (
    input  logic [NSRC-1:0] active_i,
    output logic [31:0]     id_o,
    output logic            valid_o
);
    assign valid_o = |active_i;
    always_comb begin
        id_o = ID_NONE;
        for (int i = NSRC - 1; i >= 0; i--)
            if (active_i[i]) id_o = 32'(i);
    end
endmodule

// File: rtl/beta_irq_ctrl.sv
// beta_irq_ctrl: edge-latched, maskable interrupt controller with IDLE/ASSERT/SERVICE handshake.
import beta_irq_pkg::*;
module beta_irq_ctrl #(
    parameter int          NSRC       = 8,
    parameter logic [31:0] BASE       = 32'hFFFF_0000,
    parameter logic [31:0] IRQ_VECTOR = 32'h8000_0008
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] src,
    input  logic [31:0]     ia,
    beta_irq_ctrl_if.slave  bus,
    output logic            irq
);
    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_ASSERT = ASSERT;
    localparam logic [1:0] ST_SERVICE = SERVICE;
    logic [NSRC-1:0] src_prev_q, pending_q, pending_d, mask_q, mask_d, active, wbits;
    logic [1:0]      state_q, state_d, off;
    logic [31:0]     id;
    logic            valid, wr, eoi;
    assign bus.irqHit = bus.memAddr[31:4] == BASE[31:4];
    assign off = bus.memAddr[3:2];
    assign wr = bus.irqHit && bus.MemWrite;
    assign wbits = bus.memWriteData[NSRC-1:0];
    assign eoi = wr && off == OFF_EOI;
    assign active = pending_q & mask_q;
    assign irq = state_q == ST_ASSERT;
    irq_prio_enc #(.NSRC(NSRC)) u_prio (
        .active_i(active),
        .id_o    (id),
        .valid_o (valid)
    );
    assign bus.irqReadData = !(bus.irqHit && bus.MemRead) ? '0 :
                             off == OFF_PEND ? 32'(pending_q) :
                             off == OFF_MASK ? 32'(mask_q) :
                             off == OFF_EOI  ? id : '0;
    always_comb begin
        // a new rise is OR-ed in after the clear so it beats a same-cycle CLR
        pending_d = (pending_q & ~((wr && off == OFF_CLR) ? wbits : '0)) | (src & ~src_prev_q);
        mask_d = (wr && off == OFF_MASK) ? wbits : mask_q;
        case (state_q)
            ST_IDLE:    state_d = valid ? ST_ASSERT : ST_IDLE;
            ST_ASSERT:  state_d = ia == IRQ_VECTOR ? ST_SERVICE : valid ? ST_ASSERT : ST_IDLE;
            ST_SERVICE: state_d = eoi ? ST_IDLE : ST_SERVICE;
            default:    state_d = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk) src_prev_q <= src;
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
            mask_q <= '0;
            state_q <= ST_IDLE;
        end else begin
            pending_q <= pending_d;
            mask_q <= mask_d;
            state_q <= state_d;
        end
    end
endmodule

// File: tb/tb_beta_irq_ctrl.sv
// tb_beta_irq_ctrl: directed scenario tests for beta_irq_ctrl with hand-computed expectations.
module tb_beta_irq_ctrl;
    localparam logic [31:0] BASE = 32'hFFFF_0000;
    localparam logic [31:0] VEC = 32'h8000_0008;
    localparam logic [31:0] A_PEND = BASE;
    localparam logic [31:0] A_MASK = BASE + 32'h4;
    localparam logic [31:0] A_CLR = BASE + 32'h8;
    localparam logic [31:0] A_EOI = BASE + 32'hC;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [7:0] src = '0;
    logic [31:0] ia = '0;
    logic irq;
    logic [31:0] d;
    int n_cmp = 0;
    int n_err = 0;
    beta_irq_ctrl_if bus();
    beta_irq_ctrl #(.NSRC(8), .BASE(BASE), .IRQ_VECTOR(VEC)) dut (
        .clk  (clk),
        .reset(reset),
        .src  (src),
        .ia   (ia),
        .bus  (bus),
        .irq  (irq)
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic wr(input logic [31:0] a, input logic [31:0] v);
        bus.memAddr = a;
        bus.memWriteData = v;
        bus.MemWrite = 1'b1;
        tick();
        bus.MemWrite = 1'b0;
    endtask
    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        bus.memAddr = a;
        bus.MemRead = 1'b1;
        #1;
        v = bus.irqReadData;
        bus.MemRead = 1'b0;
    endtask
    task automatic test_reset();
        src = 8'h04;
        reset = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %0b want 0", irq); end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if (irq !== 1'b0) begin n_err++; $display("FAIL post_reset_irq cyc %0d: got %0b want 0", i, irq); end
        end
        rd(A_PEND, d);
        n_cmp++;
        if (d !== 32'h0) begin n_err++; $display("FAIL post_reset_pend: got %h want 0", d); end
        src = '0;
        tick();
    endtask
    task automatic test_decode();
        bus.memAddr = 32'h1234_0004;
        bus.MemRead = 1'b1;
        #1;
        n_cmp++;
        if (bus.irqHit !== 1'b0 || bus.irqReadData !== 32'h0) begin
            n_err++; $display("FAIL miss_decode: hit %0b data %h want 0/0", bus.irqHit, bus.irqReadData);
        end
        bus.MemRead = 1'b0;
        bus.memAddr = A_EOI;
        #1;
        n_cmp++;
        if (bus.irqHit !== 1'b1 || bus.irqReadData !== 32'h0) begin
            n_err++; $display("FAIL noread_decode: hit %0b data %h want 1/0", bus.irqHit, bus.irqReadData);
        end
    endtask
    task automatic test_basic();
        wr(A_MASK, 32'h04);
        src = 8'h04;
        tick();
        src = '0;
        rd(A_PEND, d);
        n_cmp++;
        if (d !== 32'h04 || irq !== 1'b0) begin n_err++; $display("FAIL basic_edgeN: pend %h irq %0b want 04/0", d, irq); end
        tick();
        n_cmp++;
        if (irq !== 1'b1) begin n_err++; $display("FAIL basic_assert: got %0b want 1", irq); end
        rd(A_EOI, d);
        n_cmp++;
        if (d !== 32'd2) begin n_err++; $display("FAIL basic_id: got %h want 2", d); end
        rd(BASE + 32'h5, d);
        n_cmp++;
        if (d !== 32'h04) begin n_err++; $display("FAIL byte_offset_mask: got %h want 04", d); end
        ia = VEC;
        tick();
        ia = '0;
        n_cmp++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL basic_taken: got %0b want 0", irq); end
        wr(A_CLR, 32'h04);
        wr(A_EOI, 32'h0);
        repeat (3) tick();
        rd(A_PEND, d);
        n_cmp++;
        if (irq !== 1'b0 || d !== 32'h0) begin n_err++; $display("FAIL basic_eoi: irq %0b pend %h want 0/0", irq, d); end
    endtask
    task automatic test_prio();
        wr(A_MASK, 32'hFFFF_FFFF);
        rd(A_MASK, d);
        n_cmp++;
        if (d !== 32'hFF) begin n_err++; $display("FAIL mask_width: got %h want ff", d); end
        src = 8'h22;
        tick();
        src = '0;
        tick();
        rd(A_EOI, d);
        n_cmp++;
        if (d !== 32'd1) begin n_err++; $display("FAIL prio_1: got %h want 1", d); end
        wr(A_CLR, 32'h02);
        rd(A_EOI, d);
        n_cmp++;
        if (d !== 32'd5) begin n_err++; $display("FAIL prio_5: got %h want 5", d); end
        wr(A_CLR, 32'h20);
        rd(A_EOI, d);
        n_cmp++;
        if (d !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL prio_none: got %h want ffffffff", d); end
        tick();
        n_cmp++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL prio_cleared_idle: got %0b want 0", irq); end
    endtask
    task automatic test_mask_drop();
        wr(A_MASK, 32'h10);
        src = 8'h10;
        tick();
        src = '0;
        tick();
        n_cmp++;
        if (irq !== 1'b1) begin n_err++; $display("FAIL maskdrop_assert: got %0b want 1", irq); end
        wr(A_MASK, 32'h0);
        n_cmp++;
        if (irq !== 1'b1) begin n_err++; $display("FAIL maskdrop_same: got %0b want 1", irq); end
        tick();
        n_cmp++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL maskdrop_drop: got %0b want 0", irq); end
        rd(A_PEND, d);
        n_cmp++;
        if (d !== 32'h10) begin n_err++; $display("FAIL maskdrop_pend: got %h want 10", d); end
        wr(A_CLR, 32'h10);
    endtask
    task automatic test_service();
        wr(A_MASK, 32'h08);
        src = 8'h08;
        tick();
        src = '0;
        tick();
        ia = VEC;
        tick();
        ia = '0;
        wr(A_CLR, 32'h08);
        src = 8'h08;
        tick();
        src = '0;
        repeat (2) tick();
        wr(A_MASK, 32'h08);
        n_cmp++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL service_hold: got %0b want 0", irq); end
        wr(A_EOI, 32'h0);
        n_cmp++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL service_eoi_edge: got %0b want 0", irq); end
        tick();
        n_cmp++;
        if (irq !== 1'b1) begin n_err++; $display("FAIL service_reassert: got %0b want 1", irq); end
        ia = VEC;
        tick();
        ia = '0;
        wr(A_CLR, 32'h08);
        wr(A_EOI, 32'h0);
        tick();
    endtask
    task automatic test_clr_race_reset();
        wr(A_MASK, 32'h0);
        src = 8'h01;
        tick();
        src = '0;
        tick();
        src = 8'h01;
        wr(A_CLR, 32'h01);
        src = '0;
        rd(A_PEND, d);
        n_cmp++;
        if (d !== 32'h01) begin n_err++; $display("FAIL clr_race: got %h want 01", d); end
        wr(A_CLR, 32'h01);
        wr(A_PEND, 32'hFF);
        rd(A_PEND, d);
        n_cmp++;
        if (d !== 32'h0) begin n_err++; $display("FAIL pend_readonly: got %h want 0", d); end
        rd(A_CLR, d);
        n_cmp++;
        if (d !== 32'h0) begin n_err++; $display("FAIL clr_read: got %h want 0", d); end
        src = 8'h01;
        tick();
        src = '0;
        wr(A_MASK, 32'h01);
        tick();
        n_cmp++;
        if (irq !== 1'b1) begin n_err++; $display("FAIL rst_pre_assert: got %0b want 1", irq); end
        ia = VEC;
        tick();
        ia = '0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd(A_PEND, d);
        n_cmp++;
        if (irq !== 1'b0 || d !== 32'h0) begin n_err++; $display("FAIL rst_service: irq %0b pend %h want 0/0", irq, d); end
        rd(A_MASK, d);
        n_cmp++;
        if (d !== 32'h0) begin n_err++; $display("FAIL rst_mask: got %h want 0", d); end
        tick();
        n_cmp++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL rst_after: got %0b want 0", irq); end
    endtask
    initial begin
        bus.memAddr = '0;
        bus.memWriteData = '0;
        bus.MemWrite = 1'b0;
        bus.MemRead = 1'b0;
        test_reset();
        test_decode();
        test_basic();
        test_prio();
        test_mask_drop();
        test_service();
        test_clr_race_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/beta_irq_ctrl.md
# beta_irq_ctrl

Memory-mapped interrupt controller that drives the Beta core's `irq` input. It sits beside the data memory on the Beta's data bus and latches rising edges from up to `NSRC` peripheral sources. It applies a software mask and asserts `irq` through a three-state handshake that tracks the core's jump to the interrupt vector and waits for software end-of-interrupt. The top level muxes `irqReadData` onto `memReadData` whenever `irqHit` is high.

## Interface
- `NSRC`, 8 — number of interrupt sources, 1..32
- `BASE`, 32'hFFFF_0000 — register window base, 16-byte aligned; window is BASE..BASE+0xF
- `IRQ_VECTOR`, 32'h8000_0008 — `ia` value at which the core has taken the interrupt

- `clk`  in  1  — single clock, all state on posedge
- `reset`  in  1  — synchronous, active-high
- `src`  in  NSRC  — interrupt sources, synchronous to `clk`, no internal synchronizer
- `ia`  in  32  — Beta instruction address
- `memAddr`  in  32  — Beta data address
- `memWriteData`  in  32  — Beta store data
- `MemWrite`  in  1  — Beta store strobe
- `MemRead`  in  1  — Beta load strobe
- `irqReadData`  out  32  — register read data, combinational
- `irqHit`  out  1  — `memAddr[31:4] == BASE[31:4]`, combinational
- `irq`  out  1  — interrupt request to the Beta

## Operation
- Edge detect: `rise = src & ~srcPrev`. Each `rise[i]` sets `pending[i]`. `srcPrev` registers `src` every cycle, including during reset.
- `active = pending & mask`. `ID` is the lowest-numbered set bit of `active`, or 32'hFFFF_FFFF if `active` is zero.
- Registers, by word offset (`memAddr[3:2]`):
  - +0x0 PEND: read-only, returns `pending`.
  - +0x4 MASK: read/write, reset value 0.
  - +0x8 CLR: write-1-to-clear `pending`; reads return 0.
  - +0xC EOI/ID: a write of any value signals EOI; a read returns `ID`.
- Register access rules:
  - Bits at or above NSRC read 0 and ignore writes.
  - Writes to PEND are ignored.
  - `memAddr[1:0]` is ignored.
  - Access happens only when `irqHit` is high and the matching strobe is high.
- `irqReadData` is 0 unless `irqHit && MemRead`.
- FSM states are IDLE, ASSERT, SERVICE. `irq = (state == ASSERT)`, decoded from the state register.
  - IDLE → ASSERT when `|active`.
  - ASSERT → SERVICE when `ia == IRQ_VECTOR`.
  - ASSERT → IDLE when `active == 0` (software masked or cleared the source before the interrupt was taken). The SERVICE check has priority.
  - SERVICE → IDLE on an EOI write. Other writes, and any new pending bits, do not leave SERVICE.
- Simultaneous events:
  - A set of `pending[i]` wins over a CLR of the same bit in the same cycle.
  - An EOI arriving together with `|active` goes to IDLE. The FSM then enters ASSERT on the next cycle; no request is lost.
  - A MASK write takes effect on `active` starting the following cycle.
- Reset, including mid-service: `pending` = 0, `mask` = 0, state = IDLE, `irq` = 0. Because `srcPrev` follows `src` during reset, a source held high through reset does not fire afterwards.

## Timing
- A rise sampled at edge N sets `pending` after edge N.
- The FSM enters ASSERT after edge N+1, so `irq` is high in the cycle following edge N+1. Latency is 2 cycles.
- `irq` stays high until the cycle after `ia == IRQ_VECTOR` is sampled; it drops after that edge.
- Reads are zero-wait: data is valid in the same cycle as `MemRead`.
- Writes commit at the posedge where `MemWrite` is high.
- Outputs after reset: `irq` = 0. `irqReadData` and `irqHit` are purely combinational from the inputs and state.

## Structure
- `beta_irq_pkg` holds:
  - the `irq_state_t` enum (IDLE, ASSERT, SERVICE);
  - offset constants `OFF_PEND`, `OFF_MASK`, `OFF_CLR`, `OFF_EOI` (0, 1, 2, 3, word index);
  - `ID_NONE` = 32'hFFFF_FFFF.
- Sub-module `irq_prio_enc` (parameter NSRC) maps `active` to `ID` and a `valid` flag. It is shared with the EOI/ID read path.

## Test plan
- Reset held 3 cycles with `src[2]` = 1, then released → PEND reads 0 and `irq` stays 0 for 10 cycles.
- MASK = 0x04, pulse `src[2]` at edge N → PEND = 0x04 after N, `irq` = 1 after N+1. Drive `ia` = 0x8000_0008 → `irq` = 0 the next cycle. ID reads 2. Write CLR = 0x04 then EOI → FSM back in IDLE, `irq` stays 0.
- MASK = 0xFF, rise on `src[5]` and `src[1]` in the same cycle → ID reads 1. After CLR = 0x02, ID reads 5; after CLR = 0x20, ID reads 0xFFFF_FFFF.
- In ASSERT, write MASK = 0 before the vector is reached → `irq` drops the next cycle and the FSM returns to IDLE. PEND still shows the bit.
- In SERVICE, a new rise on `src[3]` (masked in) → `irq` stays 0 until the EOI write, then goes high 1 cycle after EOI.
- In the same cycle, a CLR of bit 0 and a rise on `src[0]` → PEND bit 0 = 1. Assert reset during SERVICE → `irq` = 0, PEND = 0, MASK = 0.
